// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SUMP SPI command slave: opcodes, receive FSM
// encoding and the bit that marks a long command.
package spi_cmd_pkg;

  localparam logic [7:0] OP_RESET       = 8'h00;
  localparam logic [7:0] OP_RUN         = 8'h01;
  localparam logic [7:0] OP_QUERY_ID    = 8'h02;
  localparam logic [7:0] OP_QUERY_META  = 8'h04;
  localparam logic [7:0] OP_QUERY_INPUT = 8'h06;

  // Opcodes with this bit set carry a data payload.
  localparam int LONG_BIT = 7;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_OPCODE,
    RX_DATA
  } rx_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings sclk/cs/mosi into the clock domain and turns sclk transitions into
// one-cycle sample/shift strobes for the configured CPOL/CPHA.
module spi_edge_sync #(
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic extReset_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sync_cs,
  output logic sync_mosi,
  output logic sample_stb,
  output logic shift_stb
);

  logic [SYNC_STAGES-1:0] sclk_ff;
  logic [SYNC_STAGES-1:0] cs_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   leading;
  logic                   trailing;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      sclk_ff   <= {SYNC_STAGES{CPOL}};
      cs_ff     <= '1;
      mosi_ff   <= '0;
      sclk_prev <= CPOL;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs};
      mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_ff[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_ff[SYNC_STAGES-1];
  assign sync_cs   = cs_ff[SYNC_STAGES-1];
  assign sync_mosi = mosi_ff[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign leading  = (sclk_s != sclk_prev) && (sclk_s != CPOL);
  assign trailing = (sclk_s != sclk_prev) && (sclk_s == CPOL);

  // Gating with the current cs lets a coincident cs rise swallow the edge.
  assign sample_stb = ~sync_cs & (CPHA ? trailing : leading);
  assign shift_stb  = ~sync_cs & (CPHA ? leading : trailing);

endmodule

// File: rtl/spi_cmd_slave.sv
// SUMP-protocol SPI command slave with configurable payload width, SPI mode
// and byte-masked transmit. Define SPI_FRAME_ERR_EN to build frame_err.
module spi_cmd_slave
  import spi_cmd_pkg::*;
#(
  parameter int   DATA_W      = 32,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  extReset_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  send,
  input  logic [DATA_W-1:0]     send_data,
  input  logic [DATA_W/8-1:0]   send_valid,
  output logic [DATA_W+7:0]     cmd,
  output logic                  execute,
  output logic                  busy,
  output logic                  query_id,
  output logic                  query_metadata,
  output logic                  query_dataIn,
  output logic                  frame_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TXCW   = $clog2(DATA_W + 1);

  logic sync_cs, sync_mosi, sample_stb, shift_stb;
  logic cs_q, cs_fall, cs_rise;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock      (clock),
    .extReset_n (extReset_n),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .sync_cs    (sync_cs),
    .sync_mosi  (sync_mosi),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  assign cs_fall = cs_q & ~sync_cs;
  assign cs_rise = ~cs_q & sync_cs;

  rx_state_e          state, state_next;
  logic [2:0]         bit_cnt, bit_cnt_next;
  logic [BCW-1:0]     byte_cnt, byte_cnt_next;
  logic [6:0]         shift_reg, shift_next;
  logic [7:0]         byte_val;
  logic [7:0]         opcode, opcode_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic [DATA_W+7:0]  cmd_next;
  logic               exec_next;

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) state <= RX_IDLE;
    else             state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    byte_cnt_next = byte_cnt;
    shift_next    = shift_reg;
    opcode_next   = opcode;
    data_next     = data_reg;
    cmd_next      = cmd;
    exec_next     = 1'b0;
    byte_val      = {shift_reg, sync_mosi};

    if (cs_rise) begin
      state_next    = RX_IDLE;
      bit_cnt_next  = '0;
      byte_cnt_next = '0;
    end else begin
      case (state)
        RX_IDLE: if (cs_fall) state_next = RX_OPCODE;
        RX_OPCODE, RX_DATA: begin
          if (sample_stb) begin
            shift_next   = byte_val[6:0];
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == RX_OPCODE) begin
                // A byte arriving during a readout is host filler, not a command.
                if (!busy) begin
                  if (!byte_val[LONG_BIT]) begin
                    cmd_next  = {{DATA_W{1'b0}}, byte_val};
                    exec_next = 1'b1;
                  end else begin
                    opcode_next   = byte_val;
                    byte_cnt_next = '0;
                    state_next    = RX_DATA;
                  end
                end
              end else begin
                data_next[int'(byte_cnt)*8 +: 8] = byte_val;
                if (byte_cnt == BCW'(NBYTES - 1)) begin
                  cmd_next      = {data_next, opcode};
                  exec_next     = 1'b1;
                  byte_cnt_next = '0;
                  state_next    = RX_OPCODE;
                end else begin
                  byte_cnt_next = byte_cnt + 1'b1;
                end
              end
            end
          end
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      cs_q           <= 1'b1;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      shift_reg      <= '0;
      opcode         <= '0;
      data_reg       <= '0;
      cmd            <= '0;
      execute        <= 1'b0;
      query_id       <= 1'b0;
      query_metadata <= 1'b0;
      query_dataIn   <= 1'b0;
    end else begin
      cs_q           <= sync_cs;
      bit_cnt        <= bit_cnt_next;
      byte_cnt       <= byte_cnt_next;
      shift_reg      <= shift_next;
      opcode         <= opcode_next;
      data_reg       <= data_next;
      cmd            <= cmd_next;
      execute        <= exec_next;
      query_id       <= execute && (cmd[7:0] == OP_QUERY_ID);
      query_metadata <= execute && (cmd[7:0] == OP_QUERY_META);
      query_dataIn   <= execute && (cmd[7:0] == OP_QUERY_INPUT);
    end
  end

  // Valid bytes are packed at load so the shifter never has to skip gaps.
  logic [DATA_W-1:0] tx_pack, tx_shift;
  logic [TXCW-1:0]   tx_pack_bits, tx_bits;
  logic              tx_start;
  int                pack_cnt;

  always_comb begin
    tx_pack  = '0;
    pack_cnt = 0;
    for (int i = 0; i < NBYTES; i++) begin
      if (send_valid[i]) begin
        tx_pack[DATA_W-1-8*pack_cnt -: 8] = send_data[8*i +: 8];
        pack_cnt = pack_cnt + 1;
      end
    end
    tx_pack_bits = TXCW'(8 * pack_cnt);
  end

  assign tx_start = send & ~busy & (|send_valid);

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      busy     <= 1'b0;
      miso     <= 1'b0;
      tx_shift <= '0;
      tx_bits  <= '0;
    end else if (cs_rise && busy) begin
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (tx_start) begin
      busy    <= 1'b1;
      tx_bits <= tx_pack_bits;
      if (!CPHA) begin
        miso     <= tx_pack[DATA_W-1];
        tx_shift <= tx_pack << 1;
      end else begin
        miso     <= 1'b0;
        tx_shift <= tx_pack;
      end
    end else if (busy) begin
      if (sample_stb && tx_bits == TXCW'(1)) begin
        busy <= 1'b0;
        miso <= 1'b0;
      end else begin
        if (sample_stb) tx_bits <= tx_bits - 1'b1;
        if (shift_stb) begin
          miso     <= tx_shift[DATA_W-1];
          tx_shift <= tx_shift << 1;
        end
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q;

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) frame_err_q <= 1'b0;
    else frame_err_q <= cs_rise &&
                        ((state != RX_IDLE && (bit_cnt != 3'd0 || state == RX_DATA)) || busy);
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench: mode 0 / 32-bit slave for commands, readout, truncation and
// reset; three 16-bit slaves cover SPI modes 1..3.
module tb_spi_cmd_slave;

  localparam int HALF = 40;

  logic        clock = 1'b0;
  logic        extReset_n = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        sclk [4];
  logic        send = 1'b0;
  logic [31:0] send_data = '0;
  logic [3:0]  send_valid = '0;

  logic        miso0, execute0, busy0, qid0, qmeta0, qdin0, ferr0;
  logic [39:0] cmd0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  spi_cmd_slave #(.DATA_W(32), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut (
    .clock          (clock),
    .extReset_n     (extReset_n),
    .sclk           (sclk[0]),
    .cs             (cs),
    .mosi           (mosi),
    .miso           (miso0),
    .send           (send),
    .send_data      (send_data),
    .send_valid     (send_valid),
    .cmd            (cmd0),
    .execute        (execute0),
    .busy           (busy0),
    .query_id       (qid0),
    .query_metadata (qmeta0),
    .query_dataIn   (qdin0),
    .frame_err      (ferr0)
  );

  for (genvar g = 1; g < 4; g++) begin : gen_m
    localparam logic [1:0] M = 2'(g);
    logic [23:0] cmd;
    logic        execute, miso, busy, qi, qm, qd, fe;
    int          exec_cnt = 0;
    logic [23:0] last_cmd = '0;

    spi_cmd_slave #(.DATA_W(16), .CPOL(M[1]), .CPHA(M[0]), .SYNC_STAGES(2)) u_dut (
      .clock          (clock),
      .extReset_n     (extReset_n),
      .sclk           (sclk[g]),
      .cs             (cs),
      .mosi           (mosi),
      .miso           (miso),
      .send           (1'b0),
      .send_data      (16'h0000),
      .send_valid     (2'b00),
      .cmd            (cmd),
      .execute        (execute),
      .busy           (busy),
      .query_id       (qi),
      .query_metadata (qm),
      .query_dataIn   (qd),
      .frame_err      (fe)
    );

    always @(negedge clock) begin
      if (execute) begin
        exec_cnt++;
        last_cmd = cmd;
      end
    end
  end

  // Strobe bookkeeping for the mode 0 slave, sampled on the falling edge.
  int          exec_cnt0 = 0, qid_cnt = 0, qid_after = 0, qother_cnt = 0, ferr_cnt = 0;
  logic [39:0] last_cmd0 = '0;
  logic        exec_d = 1'b0;

  always @(negedge clock) begin
    if (execute0) begin
      exec_cnt0++;
      last_cmd0 = cmd0;
    end
    if (qid0) begin
      qid_cnt++;
      if (exec_d) qid_after++;
    end
    if (qmeta0 || qdin0) qother_cnt++;
    if (ferr0) ferr_cnt++;
    exec_d = execute0;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One SPI bit on slave m; r is what the host reads on miso at its sample point.
  task automatic spi_bit(input logic [1:0] m, input logic b, output logic r);
    if (!m[0]) begin
      mosi = b;
      #HALF;
      r = (m == 2'd0) ? miso0 : 1'b0;
      sclk[m] = ~m[1];
      #HALF;
      sclk[m] = m[1];
    end else begin
      sclk[m] = ~m[1];
      mosi = b;
      #HALF;
      r = (m == 2'd0) ? miso0 : 1'b0;
      sclk[m] = m[1];
      #HALF;
    end
  endtask

  task automatic spi_byte(input logic [1:0] m, input logic [7:0] b, output logic [7:0] r);
    logic bit_r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(m, b[i], bit_r);
      r[i] = bit_r;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    cs = 1'b1;
    #(2 * HALF);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] r2;
    logic       bit_r;
    int         exp_ferr;

    for (int i = 0; i < 4; i++) sclk[i] = (i >= 2);
    extReset_n = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_cmd",  cmd0, 40'h0);
    check("rst_exec", execute0, 40'h0);
    check("rst_busy", busy0, 40'h0);
    check("rst_miso", miso0, 40'h0);

    extReset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Short query-id command.
    cs_low();
    spi_byte(2'd0, 8'h02, r);
    cs_high();
    check("short_exec_cnt",  exec_cnt0, 40'd1);
    check("short_cmd",       last_cmd0, 40'h00_0000_0002);
    check("qid_width",       qid_cnt, 40'd1);
    check("qid_after_exec",  qid_after, 40'd1);
    check("short_no_other",  qother_cnt, 40'd0);

    // Long command, payload LSB byte first.
    cs_low();
    spi_byte(2'd0, 8'hC0, r);
    spi_byte(2'd0, 8'h11, r);
    spi_byte(2'd0, 8'h22, r);
    spi_byte(2'd0, 8'h33, r);
    spi_byte(2'd0, 8'h44, r);
    cs_high();
    check("long_exec_cnt", exec_cnt0, 40'd2);
    check("long_cmd",      last_cmd0, 40'h44332211C0);
    check("long_no_qid",   qid_cnt, 40'd1);
    check("long_no_other", qother_cnt, 40'd0);

    // Same long command in SPI modes 1, 2, 3 on the 16-bit slaves.
    for (int m = 1; m < 4; m++) begin
      cs_low();
      spi_byte(2'(m), 8'h81, r);
      spi_byte(2'(m), 8'hAA, r);
      spi_byte(2'(m), 8'h55, r);
      cs_high();
    end
    check("m1_exec", gen_m[1].exec_cnt, 40'd1);
    check("m1_cmd",  gen_m[1].last_cmd, 40'h55AA81);
    check("m2_exec", gen_m[2].exec_cnt, 40'd1);
    check("m2_cmd",  gen_m[2].last_cmd, 40'h55AA81);
    check("m3_exec", gen_m[3].exec_cnt, 40'd1);
    check("m3_cmd",  gen_m[3].last_cmd, 40'h55AA81);

    // Byte-masked readout: bytes 0 and 2 of 0xDEADBEEF.
    cs_low();
    @(negedge clock);
    send_data = 32'hDEADBEEF;
    send_valid = 4'b0000;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    @(negedge clock);
    check("send_nomask_busy", busy0, 40'd0);
    send_valid = 4'b0101;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    check("tx_busy_next", busy0, 40'd1);
    send_data = 32'h12345678;
    send_valid = 4'b1111;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    spi_byte(2'd0, 8'h00, r);
    check("tx_byte0", r, 40'hEF);
    check("tx_busy_mid", busy0, 40'd1);
    for (int i = 7; i >= 1; i--) begin
      spi_bit(2'd0, 1'b0, bit_r);
      r2[i] = bit_r;
    end
    check("tx_busy_15", busy0, 40'd1);
    spi_bit(2'd0, 1'b0, bit_r);
    r2[0] = bit_r;
    check("tx_busy_16", busy0, 40'd0);
    check("tx_byte1", r2, 40'hAD);
    check("tx_idle_miso", miso0, 40'd0);
    cs_high();
    check("tx_filler_dropped", exec_cnt0, 40'd2);

    // Truncated long command: cs rises 3 bits into the 2nd payload byte.
`ifdef SPI_FRAME_ERR_EN
    exp_ferr = 1;
`else
    exp_ferr = 0;
`endif
    cs_low();
    spi_byte(2'd0, 8'hC0, r);
    spi_byte(2'd0, 8'h11, r);
    spi_bit(2'd0, 1'b0, bit_r);
    spi_bit(2'd0, 1'b0, bit_r);
    spi_bit(2'd0, 1'b1, bit_r);
    cs_high();
    check("trunc_no_exec", exec_cnt0, 40'd2);
    check("trunc_ferr",    ferr_cnt, 40'(exp_ferr));
    check("trunc_cmd_held", cmd0, 40'h44332211C0);
    cs_low();
    spi_byte(2'd0, 8'h01, r);
    cs_high();
    check("after_trunc_exec", exec_cnt0, 40'd3);
    check("after_trunc_cmd",  last_cmd0, 40'h01);
    check("after_trunc_ferr", ferr_cnt, 40'(exp_ferr));

    // Reset in the middle of the 2nd readout byte.
    cs_low();
    @(negedge clock);
    send_data = 32'hDEADBEEF;
    send_valid = 4'b1111;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    spi_byte(2'd0, 8'h00, r);
    check("rst_tx_byte0", r, 40'hEF);
    spi_bit(2'd0, 1'b0, bit_r);
    spi_bit(2'd0, 1'b0, bit_r);
    spi_bit(2'd0, 1'b0, bit_r);
    check("rst_tx_miso_pre", miso0, 40'd1);
    extReset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy0, 40'd0);
    check("rst_mid_miso", miso0, 40'd0);
    check("rst_mid_cmd",  cmd0, 40'd0);
    @(negedge clock);
    cs = 1'b1;
    repeat (4) @(negedge clock);
    extReset_n = 1'b1;
    repeat (4) @(negedge clock);
    cs_low();
    spi_byte(2'd0, 8'h02, r);
    cs_high();
    check("post_rst_exec", exec_cnt0, 40'd4);
    check("post_rst_cmd",  last_cmd0, 40'h02);
    check("post_rst_qid",  qid_cnt, 40'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
